demux_lane_buffer: RTL and testbench



---
 rtl/demux_lane_buffer_pkg.sv | 31 +++
 rtl/demux_lane_fifo.sv | 72 +++++++
 rtl/demux_lane_buffer.sv | 115 +++++++++++
 tb/tb_demux_lane_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_lane_buffer_pkg.sv
// +----------------------------------------------------------------------+
// | Package  : muxdemux_defs                                             |
// | Purpose  : Lane count, lane tag width and lane index constants       |
// |            shared by the 4:1 lane mux and the receive-side demux.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package muxdemux_defs;

   localparam int NUM_LANES = 4;
   localparam int SEL_WIDTH = 2;

   typedef logic [SEL_WIDTH-1:0] lane_t;

   localparam lane_t LANE0 = 2'd0;
   localparam lane_t LANE1 = 2'd1;
   localparam lane_t LANE2 = 2'd2;
   localparam lane_t LANE3 = 2'd3;

   // One-hot decode of a lane tag
   function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_t lane);
      logic [NUM_LANES-1:0] v;
      v = '0;
      v[lane] = 1'b1;
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/demux_lane_fifo.sv
// +----------------------------------------------------------------------+
// | Module   : demux_lane_fifo                                           |
// | Purpose  : Single-lane show-ahead FIFO. Head word is presented on    |
// |            head_data while nonempty, zero otherwise.                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module demux_lane_fifo #(
   parameter int DATA_WIDTH = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  empty,
   output logic                  full
);

   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]    r_wr_ptr;
   logic [c_ptr_w-1:0]    r_rd_ptr;
   logic [c_cnt_w-1:0]    r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   // Self-protect against overflow/underflow even if the caller does not
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   assign empty     = (r_count == '0);
   assign full      = (r_count == c_full_cnt);
   assign head_data = empty ? '0 : r_mem[r_rd_ptr];

   // Storage array: contents are don't-care after reset, so no reset term
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointers wrap modulo depth; count tracks occupancy
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/demux_lane_buffer.sv
// +----------------------------------------------------------------------+
// | Module   : demux_lane_buffer                                         |
// | Purpose  : Steers a lane-tagged word stream into four per-lane FIFOs |
// |            each drained by its own valid/ready handshake.            |
// | Options  : DEMUX_PARITY_EN - adds parity_in / sticky err_parity and  |
// |            drops words failing even parity.                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module demux_lane_buffer #(
   parameter int DATA_WIDTH = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int SEL_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  enb,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [SEL_WIDTH-1:0]  dest_in,
   output logic                  ready_out,
   output logic                  valid_out0,
   output logic                  valid_out1,
   output logic                  valid_out2,
   output logic                  valid_out3,
   output logic [DATA_WIDTH-1:0] data_out0,
   output logic [DATA_WIDTH-1:0] data_out1,
   output logic [DATA_WIDTH-1:0] data_out2,
   output logic [DATA_WIDTH-1:0] data_out3,
   input  logic                  ready_in0,
   input  logic                  ready_in1,
   input  logic                  ready_in2,
   input  logic                  ready_in3
`ifdef DEMUX_PARITY_EN
   ,
   input  logic                  parity_in,
   output logic                  err_parity
`endif
);

   import muxdemux_defs::*;

   logic [NUM_LANES-1:0]  w_full;
   logic [NUM_LANES-1:0]  w_empty;
   logic [NUM_LANES-1:0]  w_push;
   logic [NUM_LANES-1:0]  w_pop;
   logic [NUM_LANES-1:0]  w_valid;
   logic [NUM_LANES-1:0]  w_ready_in;
   logic [NUM_LANES-1:0]  w_dest_hot;
   logic [DATA_WIDTH-1:0] w_head [NUM_LANES];
   logic                  w_accept;
   logic                  w_store;

   assign w_ready_in = {ready_in3, ready_in2, ready_in1, ready_in0};
   assign w_dest_hot = lane_onehot(lane_t'(dest_in));

   // Backpressure only from the lane currently addressed
   assign ready_out = enb & ~w_full[dest_in];
   assign w_accept  = valid_in & ready_out;

`ifdef DEMUX_PARITY_EN
   logic w_par_bad;
   logic r_err_parity;

   assign w_par_bad  = ^{data_in, parity_in};
   assign w_store    = w_accept & ~w_par_bad;
   assign err_parity = r_err_parity;

   // Sticky flag set by any handshaked word failing even parity
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_err_parity <= 1'b0;
      end else if (w_accept && w_par_bad) begin
         r_err_parity <= 1'b1;
      end
   end
`else
   assign w_store = w_accept;
`endif

   assign w_push  = w_dest_hot & {NUM_LANES{w_store}};
   assign w_valid = ~w_empty & {NUM_LANES{enb}};
   assign w_pop   = w_valid & w_ready_in;

   generate
      for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
         demux_lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk       (clk),
            .reset_L   (reset_L),
            .push      (w_push[i]),
            .push_data (data_in),
            .pop       (w_pop[i]),
            .head_data (w_head[i]),
            .empty     (w_empty[i]),
            .full      (w_full[i])
         );
      end
   endgenerate

   assign valid_out0 = w_valid[LANE0];
   assign valid_out1 = w_valid[LANE1];
   assign valid_out2 = w_valid[LANE2];
   assign valid_out3 = w_valid[LANE3];
   assign data_out0  = w_head[LANE0];
   assign data_out1  = w_head[LANE1];
   assign data_out2  = w_head[LANE2];
   assign data_out3  = w_head[LANE3];

endmodule

`default_nettype wire

// File: tb/tb_demux_lane_buffer.sv
// +----------------------------------------------------------------------+
// | Module   : tb_demux_lane_buffer                                      |
// | Purpose  : Directed self-checking bench for demux_lane_buffer.       |
// |            Parity tests compile in when DEMUX_PARITY_EN is defined.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_demux_lane_buffer;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       enb;
   logic       valid_in;
   logic [3:0] data_in;
   logic [1:0] dest_in;
   logic       ready_out;
   logic       valid_out0, valid_out1, valid_out2, valid_out3;
   logic [3:0] data_out0, data_out1, data_out2, data_out3;
   logic       ready_in0, ready_in1, ready_in2, ready_in3;
`ifdef DEMUX_PARITY_EN
   logic       par_flip;
   logic       parity_in;
   logic       err_parity;
   assign parity_in = (^data_in) ^ par_flip;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   demux_lane_buffer #(
      .DATA_WIDTH (4),
      .FIFO_DEPTH (4),
      .SEL_WIDTH  (2)
   ) dut (
      .clk        (clk),
      .reset_L    (reset_L),
      .enb        (enb),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .dest_in    (dest_in),
      .ready_out  (ready_out),
      .valid_out0 (valid_out0),
      .valid_out1 (valid_out1),
      .valid_out2 (valid_out2),
      .valid_out3 (valid_out3),
      .data_out0  (data_out0),
      .data_out1  (data_out1),
      .data_out2  (data_out2),
      .data_out3  (data_out3),
      .ready_in0  (ready_in0),
      .ready_in1  (ready_in1),
      .ready_in2  (ready_in2),
      .ready_in3  (ready_in3)
`ifdef DEMUX_PARITY_EN
      ,
      .parity_in  (parity_in),
      .err_parity (err_parity)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then settle so outputs are sampled away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [1:0] d, input logic [3:0] w);
      valid_in = 1'b1;
      dest_in  = d;
      data_in  = w;
   endtask

   function automatic logic [3:0] valids();
      return {valid_out3, valid_out2, valid_out1, valid_out0};
   endfunction

   initial begin
      logic [3:0] exp_seq [4];

      reset_L  = 1'b0;
      enb      = 1'b1;
      valid_in = 1'b0;
      data_in  = 4'h0;
      dest_in  = 2'd0;
      {ready_in3, ready_in2, ready_in1, ready_in0} = 4'b0000;
`ifdef DEMUX_PARITY_EN
      par_flip = 1'b0;
`endif

      // ---- 1. reset behaviour ----
      offer(2'd2, 4'hA);
      tick();
      tick();
      check("rst_ready_enb1", ready_out, 1);
      check("rst_valids", valids(), 4'b0000);
      check("rst_data", {data_out3, data_out2, data_out1, data_out0}, 16'h0000);
`ifdef DEMUX_PARITY_EN
      check("rst_err", err_parity, 0);
`endif
      enb = 1'b0;
      #1;
      check("rst_ready_enb0", ready_out, 0);
      enb = 1'b1;
      reset_L = 1'b1;
      tick();
      valid_in = 1'b0;
      check("push_l2_valid", valids(), 4'b0100);
      check("push_l2_data", data_out2, 4'hA);
      ready_in2 = 1'b1;
      tick();
      ready_in2 = 1'b0;
      check("drain_l2_empty", valids(), 4'b0000);

      // ---- 2. fill lane 1 and backpressure ----
      for (int i = 1; i <= 4; i++) begin
         offer(2'd1, 4'(i));
         tick();
      end
      offer(2'd1, 4'h5);
      #1;
      check("full_l1_ready", ready_out, 0);
      dest_in = 2'd0;
      #1;
      check("l0_ready_while_l1_full", ready_out, 1);
      valid_in = 1'b0;
      ready_in1 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("drain_l1_order", data_out1, 4'(i));
         tick();
      end
      check("drain_l1_empty", valid_out1, 0);
      ready_in1 = 1'b0;

      // ---- 3. push/pop on a full lane 3, then wrap ----
      for (int i = 6; i <= 9; i++) begin
         offer(2'd3, 4'(i));
         tick();
      end
      ready_in3 = 1'b1;
      offer(2'd3, 4'hB);
      #1;
      check("full_l3_ready", ready_out, 0);
      tick();
      ready_in3 = 1'b0;
      check("l3_head_after_pop", data_out3, 4'h7);
      check("l3_reoffer_ready", ready_out, 1);
      tick();
      valid_in = 1'b0;
      ready_in3 = 1'b1;
      exp_seq = '{4'h7, 4'h8, 4'h9, 4'hB};
      for (int i = 0; i < 4; i++) begin
         check("drain_l3_wrap", data_out3, exp_seq[i]);
         tick();
      end
      check("drain_l3_empty", valid_out3, 0);

      // ---- 4. interleaved stream, all consumers ready ----
      {ready_in3, ready_in2, ready_in1, ready_in0} = 4'b1111;
      offer(2'd0, 4'hE);
      tick();
      check("il_l0_valid", valids(), 4'b0001);
      check("il_l0_data", data_out0, 4'hE);
      offer(2'd1, 4'hE);
      tick();
      check("il_l1_valid", valids(), 4'b0010);
      check("il_l1_data", data_out1, 4'hE);
      offer(2'd2, 4'hC);
      tick();
      check("il_l2_data", data_out2, 4'hC);
      offer(2'd3, 4'h8);
      tick();
      check("il_l3_data", data_out3, 4'h8);
      offer(2'd0, 4'h1);
      tick();
      check("il_l0_second", data_out0, 4'h1);
      check("il_l0_second_v", valids(), 4'b0001);
      valid_in = 1'b0;
      tick();
      check("il_all_empty", valids(), 4'b0000);

      // ---- 5. enable toggling retains state ----
      {ready_in3, ready_in2, ready_in1, ready_in0} = 4'b0000;
      offer(2'd0, 4'h3);
      tick();
      offer(2'd0, 4'h5);
      tick();
      enb = 1'b0;
      ready_in0 = 1'b1;
      offer(2'd0, 4'hF);
      #1;
      check("enb0_valid", valid_out0, 0);
      check("enb0_ready", ready_out, 0);
      tick();
      tick();
      tick();
      valid_in = 1'b0;
      ready_in0 = 1'b0;
      enb = 1'b1;
      #1;
      check("enb1_valid", valid_out0, 1);
      check("enb1_head", data_out0, 4'h3);
      ready_in0 = 1'b1;
      tick();
      check("enb1_second", data_out0, 4'h5);
      tick();
      check("enb1_drained", valid_out0, 0);
      ready_in0 = 1'b0;

      // ---- async reset mid-operation ----
      offer(2'd1, 4'h9);
      tick();
      valid_in = 1'b0;
      check("pre_areset_valid", valid_out1, 1);
      #2;
      reset_L = 1'b0;
      #1;
      check("areset_valid", valid_out1, 0);
      check("areset_data", data_out1, 4'h0);
      #1;
      reset_L = 1'b1;
      tick();
      check("post_areset_valids", valids(), 4'b0000);

`ifdef DEMUX_PARITY_EN
      // ---- 6. parity drop and sticky error ----
      par_flip = 1'b1;
      offer(2'd0, 4'b0111);
      tick();
      valid_in = 1'b0;
      check("par_err_set", err_parity, 1);
      check("par_dropped", valid_out0, 0);
      par_flip = 1'b0;
      offer(2'd0, 4'b0111);
      tick();
      valid_in = 1'b0;
      check("par_stored_v", valid_out0, 1);
      check("par_stored_d", data_out0, 4'b0111);
      check("par_err_sticky", err_parity, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
